// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider.
package div_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        RUN   = 3'd2,
        FIX   = 3'd3,
        HOLD  = 3'd4
    } div_state_t;

    localparam int DEFAULT_WIDTH = 32;
    localparam int ITER_LAST     = DEFAULT_WIDTH - 1;

endpackage

// File: rtl/div_step.sv
// Purpose: one restoring-division iteration (shift in next dividend bit, conditional subtract).
// Latency: purely combinational, zero cycles.
// Backpressure: none; evaluated every cycle, consumed only while the divider runs.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_nxt,
    output logic [WIDTH-1:0] q_nxt
);

    logic [WIDTH+1:0] shifted;
    logic             ge;

    assign shifted = {rem, q[WIDTH-1]};
    assign ge      = shifted >= {2'b00, divisor};
    assign rem_nxt = ge ? (shifted[WIDTH:0] - {1'b0, divisor}) : shifted[WIDTH:0];
    assign q_nxt   = {q[WIDTH-2:0], ge};

endmodule

// File: rtl/div_unit.sv
// Purpose: iterative 32-bit divider producing HI (remainder) / LO (quotient); DIV_SIGNED_EN selects signed semantics.
// Latency: fixed 34 cycles from the start edge to DivOut; divide-by-zero reports 1 cycle after CHECK.
// Backpressure: none; a held DivCtrl is absorbed in HOLD so each request level yields exactly one result.
module div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             DivCtrl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             DivOut,
    output logic             divZero
);

    div_state_t state, state_nxt;

    logic [WIDTH-1:0] a_reg, b_reg, q_reg, div_reg;
    logic [WIDTH:0]   rem_reg, rem_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic [5:0]       cnt;

    logic             ld_ops, check_ok, zero_hit, run_en, fix_en;
    logic [WIDTH-1:0] abs_a, abs_b, q_res, rem_res;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem     (rem_reg),
        .q       (q_reg),
        .divisor (div_reg),
        .rem_nxt (rem_nxt),
        .q_nxt   (q_nxt)
    );

`ifdef DIV_SIGNED_EN
    // Magnitude divide, then quotient sign = sign(A)^sign(B), remainder sign = sign(A).
    logic neg_a, neg_b;
    assign neg_a   = a_reg[WIDTH-1];
    assign neg_b   = b_reg[WIDTH-1];
    assign abs_a   = neg_a ? -a_reg : a_reg;
    assign abs_b   = neg_b ? -b_reg : b_reg;
    assign q_res   = (neg_a ^ neg_b) ? -q_reg : q_reg;
    assign rem_res = neg_a ? -rem_reg[WIDTH-1:0] : rem_reg[WIDTH-1:0];
`else
    assign abs_a   = a_reg;
    assign abs_b   = b_reg;
    assign q_res   = q_reg;
    assign rem_res = rem_reg[WIDTH-1:0];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (DivCtrl) state_nxt = CHECK;
            CHECK:   state_nxt = (b_reg == '0) ? HOLD : RUN;
            RUN:     if (cnt == 6'(ITER_LAST)) state_nxt = FIX;
            FIX:     state_nxt = HOLD;
            HOLD:    if (!DivCtrl) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ld_ops   = (state == IDLE) && DivCtrl;
        check_ok = (state == CHECK) && (b_reg != '0);
        zero_hit = (state == CHECK) && (b_reg == '0);
        run_en   = (state == RUN);
        fix_en   = (state == FIX);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg   <= '0;
            b_reg   <= '0;
            q_reg   <= '0;
            div_reg <= '0;
            rem_reg <= '0;
            cnt     <= '0;
            HI      <= '0;
            LO      <= '0;
            DivOut  <= 1'b0;
            divZero <= 1'b0;
        end else begin
            DivOut  <= fix_en;
            divZero <= zero_hit;
            if (ld_ops) begin
                a_reg <= A;
                b_reg <= B;
                cnt   <= '0;
            end
            if (check_ok) begin
                q_reg   <= abs_a;
                div_reg <= abs_b;
                rem_reg <= '0;
            end
            if (run_en) begin
                rem_reg <= rem_nxt;
                q_reg   <= q_nxt;
                cnt     <= cnt + 6'd1;
            end
            if (fix_en) begin
                LO <= q_res;
                HI <= rem_res;
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit; inputs driven and outputs sampled on the falling edge.
module tb_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         DivCtrl;
    logic [W-1:0] A, B, HI, LO;
    logic         DivOut, divZero;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    div_unit #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .DivCtrl (DivCtrl),
        .A       (A),
        .B       (B),
        .HI      (HI),
        .LO      (LO),
        .DivOut  (DivOut),
        .divZero (divZero)
    );

    // Start one request, corrupt the operands right after the start edge, and
    // return the number of edges until DivOut or divZero (-1 on timeout).
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
        @(negedge clk);
        @(negedge clk);
        DivCtrl = 1'b1;
        A = a;
        B = b;
        @(negedge clk);
        DivCtrl = 1'b0;
        A = ~a;
        B = ~b;
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (DivOut || divZero) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        DivCtrl = 1'b0;
        A = '0;
        B = '0;
        repeat (3) @(negedge clk);
        total++; if (HI !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h exp=%h", HI, 32'h0); end
        total++; if (LO !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h exp=%h", LO, 32'h0); end
        total++; if (DivOut !== 1'b0) begin bad++; $display("FAIL reset_divout got=%b exp=0", DivOut); end
        total++; if (divZero !== 1'b0) begin bad++; $display("FAIL reset_divzero got=%b exp=0", divZero); end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int lat;
        run_div(32'd7, 32'd2, lat);
        total++; if (lat !== 34) begin bad++; $display("FAIL basic_latency got=%0d exp=34", lat); end
        total++; if (DivOut !== 1'b1 || divZero !== 1'b0) begin bad++; $display("FAIL basic_pulse got=%b%b exp=10", DivOut, divZero); end
        total++; if (LO !== 32'd3) begin bad++; $display("FAIL basic_lo got=%h exp=%h", LO, 32'd3); end
        total++; if (HI !== 32'd1) begin bad++; $display("FAIL basic_hi got=%h exp=%h", HI, 32'd1); end
        @(negedge clk);
        total++; if (DivOut !== 1'b0) begin bad++; $display("FAIL basic_one_cycle got=%b exp=0", DivOut); end
    endtask

    task automatic test_wide();
        int lat;
`ifdef DIV_SIGNED_EN
        run_div(32'hFFFF_FFF9, 32'd2, lat);
        total++; if (lat !== 34) begin bad++; $display("FAIL neg_latency got=%0d exp=34", lat); end
        total++; if (LO !== 32'hFFFF_FFFD) begin bad++; $display("FAIL neg_lo got=%h exp=%h", LO, 32'hFFFF_FFFD); end
        total++; if (HI !== 32'hFFFF_FFFF) begin bad++; $display("FAIL neg_hi got=%h exp=%h", HI, 32'hFFFF_FFFF); end
        run_div(32'h8000_0000, 32'hFFFF_FFFF, lat);
        total++; if (lat !== 34) begin bad++; $display("FAIL ovf_latency got=%0d exp=34", lat); end
        total++; if (LO !== 32'h8000_0000) begin bad++; $display("FAIL ovf_lo got=%h exp=%h", LO, 32'h8000_0000); end
        total++; if (HI !== 32'h0) begin bad++; $display("FAIL ovf_hi got=%h exp=%h", HI, 32'h0); end
`else
        run_div(32'hFFFF_FFFF, 32'd2, lat);
        total++; if (lat !== 34) begin bad++; $display("FAIL umax_latency got=%0d exp=34", lat); end
        total++; if (LO !== 32'h7FFF_FFFF) begin bad++; $display("FAIL umax_lo got=%h exp=%h", LO, 32'h7FFF_FFFF); end
        total++; if (HI !== 32'd1) begin bad++; $display("FAIL umax_hi got=%h exp=%h", HI, 32'd1); end
`endif
    endtask

    task automatic test_div_zero();
        int lat;
        int n_out;
        int n_zero;
        run_div(32'h451, 32'h20, lat);
        total++; if (LO !== 32'h22 || HI !== 32'h11) begin bad++; $display("FAIL zero_setup got=%h/%h exp=00000011/00000022", HI, LO); end
        run_div(32'd5, 32'd0, lat);
        total++; if (lat !== 1) begin bad++; $display("FAIL zero_latency got=%0d exp=1", lat); end
        total++; if (divZero !== 1'b1 || DivOut !== 1'b0) begin bad++; $display("FAIL zero_pulse got=%b%b exp=10", divZero, DivOut); end
        n_out = 0;
        n_zero = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (DivOut) n_out++;
            if (divZero) n_zero++;
        end
        total++; if (n_zero !== 0) begin bad++; $display("FAIL zero_one_cycle got=%0d exp=0", n_zero); end
        total++; if (n_out !== 0) begin bad++; $display("FAIL zero_no_divout got=%0d exp=0", n_out); end
        total++; if (HI !== 32'h11) begin bad++; $display("FAIL zero_hi_kept got=%h exp=%h", HI, 32'h11); end
        total++; if (LO !== 32'h22) begin bad++; $display("FAIL zero_lo_kept got=%h exp=%h", LO, 32'h22); end
    endtask

    task automatic test_back_to_back();
        int n_out;
        int lat;
        @(negedge clk);
        @(negedge clk);
        DivCtrl = 1'b1;
        A = 32'd100;
        B = 32'd7;
        n_out = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (DivOut) n_out++;
        end
        DivCtrl = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (DivOut) n_out++;
        end
        total++; if (n_out !== 1) begin bad++; $display("FAIL held_one_shot got=%0d exp=1", n_out); end
        total++; if (LO !== 32'd14 || HI !== 32'd2) begin bad++; $display("FAIL held_result got=%h/%h exp=00000002/0000000e", HI, LO); end
        run_div(32'd9, 32'd3, lat);
        total++; if (lat !== 34) begin bad++; $display("FAIL restart_latency got=%0d exp=34", lat); end
        total++; if (LO !== 32'd3) begin bad++; $display("FAIL restart_lo got=%h exp=%h", LO, 32'd3); end
        total++; if (HI !== 32'd0) begin bad++; $display("FAIL restart_hi got=%h exp=%h", HI, 32'd0); end
    endtask

    task automatic test_reset_mid();
        int n_out;
        int lat;
        @(negedge clk);
        @(negedge clk);
        DivCtrl = 1'b1;
        A = 32'd100;
        B = 32'd7;
        @(negedge clk);
        DivCtrl = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++; if (LO !== 32'h0 || HI !== 32'h0) begin bad++; $display("FAIL midreset_hilo got=%h/%h exp=0/0", HI, LO); end
        total++; if (DivOut !== 1'b0 || divZero !== 1'b0) begin bad++; $display("FAIL midreset_pulses got=%b%b exp=00", DivOut, divZero); end
        reset = 1'b0;
        n_out = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (DivOut || divZero) n_out++;
        end
        total++; if (n_out !== 0) begin bad++; $display("FAIL midreset_no_pulse got=%0d exp=0", n_out); end
        run_div(32'd7, 32'd2, lat);
        total++; if (lat !== 34 || LO !== 32'd3 || HI !== 32'd1) begin bad++; $display("FAIL midreset_recover got=lat%0d %h/%h exp=lat34 00000001/00000003", lat, HI, LO); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wide();
        test_div_zero();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
